// File: rtl/hack_screen_fetch.sv
// Hack screen fetch: maps the VGA raster onto screen-RAM words, one read per word,
// and returns a latency-aligned 24-bit pixel. Optional HACK_SCREEN_SCALE2_EN doubles each Hack pixel.
`timescale 1ns/1ps
module hack_screen_fetch #(
  parameter logic [10:0] H_START    = 11'd144,
  parameter logic [10:0] V_START    = 11'd112,
  parameter int          SCREEN_W   = 512,
  parameter int          SCREEN_H   = 256,
  parameter int          WORD_BITS  = 16,
  parameter int          ADDR_W     = 13,
  parameter int          RAM_LAT    = 1,
  parameter logic [2:0]  FG_RGB     = 3'b000,
  parameter logic [2:0]  BG_RGB     = 3'b111,
  parameter logic [2:0]  BORDER_RGB = 3'b001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [10:0]          vga_h,
  input  logic [10:0]          vga_v,
  input  logic [WORD_BITS-1:0] read_value,
  input  logic                 overlay_on,
  input  logic [2:0]           overlay_rgb,
  output logic [ADDR_W-1:0]    read_address,
  output logic                 read_en,
  output logic [23:0]          pixel_out,
  output logic                 in_window
);
  localparam int IDX_W = $clog2(WORD_BITS);
`ifdef HACK_SCREEN_SCALE2_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif

  typedef struct packed {
    logic             win;
    logic [IDX_W-1:0] idx;
    logic             en;
    logic             ov;
    logic [2:0]       rgb;
  } stg_t;

  function automatic logic [23:0] rgb24(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  logic [31:0] h32, v32, x_raw, y_raw, x_pix, y_pix;
  logic        win, fetch;
  logic [ADDR_W-1:0] word;

  always_comb begin
    h32   = {21'b0, vga_h};
    v32   = {21'b0, vga_v};
    win   = (h32 >= 32'(H_START)) && (h32 < 32'(H_START) + 32'(SCALE*SCREEN_W)) &&
            (v32 >= 32'(V_START)) && (v32 < 32'(V_START) + 32'(SCALE*SCREEN_H));
    x_raw = h32 - 32'(H_START);
    y_raw = v32 - 32'(V_START);
    x_pix = x_raw >> (SCALE-1);
    y_pix = y_raw >> (SCALE-1);
    word  = ADDR_W'((y_pix*32'(SCREEN_W) + x_pix) / 32'(WORD_BITS));
`ifdef HACK_SCREEN_SCALE2_EN
    fetch = win && (x_pix[IDX_W-1:0] == '0) && !x_raw[0];
`else
    fetch = win && (x_pix[IDX_W-1:0] == '0);
`endif
  end

  // stg_q[k] is the pixel context k clocks after the address register
  stg_t [RAM_LAT:0]    stg_q, stg_d;
  logic [ADDR_W-1:0]   read_address_q, read_address_d;
  logic [WORD_BITS-1:0] latch_q, latch_d;
  logic [23:0]         pixel_q, pixel_d;
  logic                in_window_q, in_window_d;
  stg_t                last;
  logic                bit_s;

  always_comb begin
    stg_d    = stg_q;
    stg_d[0] = {win, x_pix[IDX_W-1:0], fetch, overlay_on, overlay_rgb};
    for (int k = 1; k <= RAM_LAT; k++) stg_d[k] = stg_q[k-1];
    read_address_d = win ? word : read_address_q;
    last     = stg_q[RAM_LAT];
    // bypass the latch on the clock the word arrives
    latch_d  = last.en ? read_value : latch_q;
    bit_s    = last.en ? read_value[last.idx] : latch_q[last.idx];
    if (last.ov)       pixel_d = rgb24(last.rgb);
    else if (last.win) pixel_d = rgb24(bit_s ? FG_RGB : BG_RGB);
    else               pixel_d = rgb24(BORDER_RGB);
    in_window_d = last.win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q          <= '0;
      read_address_q <= '0;
      latch_q        <= '0;
      pixel_q        <= '0;
      in_window_q    <= 1'b0;
    end else begin
      stg_q          <= stg_d;
      read_address_q <= read_address_d;
      latch_q        <= latch_d;
      pixel_q        <= pixel_d;
      in_window_q    <= in_window_d;
    end
  end

  assign read_address = read_address_q;
  assign read_en      = stg_q[0].en;
  assign pixel_out    = pixel_q;
  assign in_window    = in_window_q;
endmodule

// File: tb/tb_hack_screen_fetch.sv
// Bench for hack_screen_fetch: three instances (RAM_LAT 1..3) against a raster-level pixel model.
`timescale 1ns/1ps
module tb_hack_screen_fetch;
  localparam int HS = 144, VS = 112, WB = 16, N = 16384;
`ifdef HACK_SCREEN_SCALE2_EN
  localparam int SW = 64, SH = 32, SC = 2;
`else
  localparam int SW = 512, SH = 256, SC = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] vga_h = '0, vga_v = '0;
  logic        ovl = 1'b0;
  logic [2:0]  ovrgb = '0;
  logic [15:0] mem [8192];

  logic [12:0] ra [3];
  logic        re [3];
  logic [23:0] px [3];
  logic        iw [3];
  logic [15:0] rv [3];

  hack_screen_fetch #(.SCREEN_W(SW), .SCREEN_H(SH), .RAM_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .vga_h(vga_h), .vga_v(vga_v), .read_value(rv[0]),
    .overlay_on(ovl), .overlay_rgb(ovrgb), .read_address(ra[0]), .read_en(re[0]),
    .pixel_out(px[0]), .in_window(iw[0]));
  hack_screen_fetch #(.SCREEN_W(SW), .SCREEN_H(SH), .RAM_LAT(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .vga_h(vga_h), .vga_v(vga_v), .read_value(rv[1]),
    .overlay_on(ovl), .overlay_rgb(ovrgb), .read_address(ra[1]), .read_en(re[1]),
    .pixel_out(px[1]), .in_window(iw[1]));
  hack_screen_fetch #(.SCREEN_W(SW), .SCREEN_H(SH), .RAM_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .vga_h(vga_h), .vga_v(vga_v), .read_value(rv[2]),
    .overlay_on(ovl), .overlay_rgb(ovrgb), .read_address(ra[2]), .read_en(re[2]),
    .pixel_out(px[2]), .in_window(iw[2]));

  // screen RAMs with 1, 2 and 3 clocks of read latency
  logic [15:0] d1, d2 [2], d3 [3];
  always @(posedge clk) begin
    d1 <= mem[ra[0]];
    d2[0] <= mem[ra[1]]; d2[1] <= d2[0];
    d3[0] <= mem[ra[2]]; d3[1] <= d3[0]; d3[2] <= d3[1];
  end
  assign rv[0] = d1;
  assign rv[1] = d2[1];
  assign rv[2] = d3[2];

  int errors = 0, checks = 0, cyc = 0, pulses = 0;
  int hh [N], hvv [N];
  bit hov [N], hval [N];
  logic [2:0]  hrgb [N];
  logic [23:0] opx [3][N];
  logic        ore [N];
  logic [12:0] ora [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit in_win(int h, int v);
    return h >= HS && h < HS + SC*SW && v >= VS && v < VS + SC*SH;
  endfunction
  function automatic int word_of(int h, int v);
    return (((v-VS)/SC)*SW + (h-HS)/SC) / WB;
  endfunction
  function automatic logic [23:0] x8(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction
  function automatic logic [23:0] exp_pix(int e);
    logic [15:0] w;
    if (hov[e]) return x8(hrgb[e]);
    if (!in_win(hh[e], hvv[e])) return x8(3'b001);
    w = mem[word_of(hh[e], hvv[e])];
    return w[((hh[e]-HS)/SC) % WB] ? x8(3'b000) : x8(3'b111);
  endfunction
  function automatic bit exp_en(int e);
    return in_win(hh[e], hvv[e]) && ((hh[e]-HS) % (SC*WB) == 0);
  endfunction

  task automatic check_cycle();
    int e;
    for (int k = 0; k < 3; k++) opx[k][cyc] = px[k];
    ore[cyc] = re[0];
    ora[cyc] = ra[0];
    if (re[0]) pulses++;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        chk("rst_px", px[k], 0); chk("rst_en", re[k], 0); chk("rst_win", iw[k], 0);
      end
    end else begin
      e = cyc - 1;
      if (hval[e]) begin
        for (int k = 0; k < 3; k++) begin
          chk("rd_en", re[k], exp_en(e));
          if (exp_en(e)) chk("rd_addr", ra[k], word_of(hh[e], hvv[e]));
        end
      end
      for (int k = 0; k < 3; k++) begin
        e = cyc - k - 3;
        if (e >= 0 && hval[e]) begin
          chk($sformatf("pix_lat%0d", k+1), px[k], exp_pix(e));
          chk($sformatf("win_lat%0d", k+1), iw[k], in_win(hh[e], hvv[e]));
        end
      end
    end
  endtask

  task automatic step(int h, int v, bit o, logic [2:0] c);
    if (cyc >= N - 2) begin
      $display("FAIL cycle_budget cyc=%0d got=overrun want=<%0d", cyc, N-2);
      $fatal(1);
    end
    vga_h = 11'(h); vga_v = 11'(v); ovl = o; ovrgb = c;
    hh[cyc] = h; hvv[cyc] = v; hov[cyc] = o; hrgb[cyc] = c; hval[cyc] = rst_n;
    @(posedge clk); cyc++; #1;
    check_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_async_px", px[k], 0); chk("rst_async_en", re[k], 0); chk("rst_async_win", iw[k], 0);
    end
    for (int e = cyc - 8; e <= cyc; e++) if (e >= 0) hval[e] = 1'b0;
    for (int i = 0; i < 3; i++) step(HS + i*7, VS + 3, 1'b0, 3'b0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step(0, 0, 1'b0, 3'b0);
  endtask

  int c0, cl, cb, ca, cx, cy, h0, v, len;
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0;
    mem[0] = 16'h0001;
    mem[SW*SH/WB-1] = 16'hA5C3;
    #1;
    for (int i = 0; i < 4; i++) step(HS + i*16, VS, 1'b0, 3'b0);
    rst_n = 1'b1;

    // one full row: fetch rate, addresses and first-word pixels
    c0 = cyc; pulses = 0;
    for (int h = 0; h < 800; h++) step(h, VS, 1'b0, 3'b0);
    drain();
    chk("row_pulses", pulses, SW/WB);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j <= SC; j++)
        chk($sformatf("first_word_col%0d_lat%0d", j, k+1), opx[k][c0+HS+j+k+3],
            (j < SC) ? 24'h000000 : 24'hFFFFFF);

    // last word of the frame and the column past the window
    cl = -1;
    for (int h = HS + SC*(SW-2*WB); h < HS + SC*SW + 6; h++) begin
      if (h == HS + SC*(SW-WB)) cl = cyc;
      if (h == HS + SC*SW) cb = cyc;
      step(h, VS + SC*SH - 1, 1'b0, 3'b0);
    end
    drain();
    chk("last_en", ore[cl+1], 1);
    chk("last_addr", ora[cl+1], SW*SH/WB - 1);
    chk("past_edge_en", ore[cb+1], 0);
    chk("past_edge_px", opx[0][cb+3], 24'h0000FF);

    // border and overlay
    ca = cyc; step(HS-1, 200, 1'b0, 3'b000);
    cx = cyc; step(10, 10, 1'b1, 3'b100);
    cy = cyc; step(HS, VS+5, 1'b1, 3'b010);
    drain();
    for (int k = 0; k < 3; k++) begin
      chk("border_px", opx[k][ca+k+3], 24'h0000FF);
      chk("ovl_border_px", opx[k][cx+k+3], 24'hFF0000);
      chk("ovl_win_px", opx[k][cy+k+3], 24'h00FF00);
    end
    chk("ovl_win_fetch", ore[cy+1], 1);

    // random raster segments over random screen contents
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    for (int s = 0; s < 40; s++) begin
      if (s == 20) do_reset();
      v = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 524) : $urandom_range(VS-4, VS+SC*SH+3);
      case ($urandom_range(0, 2))
        0: h0 = $urandom_range(0, HS-1);
        1: h0 = HS + SC*WB*$urandom_range(0, SW/WB-1);
        default: h0 = $urandom_range(HS+SC*SW, 790);
      endcase
      len = $urandom_range(1, 160);
      for (int j = 0; j < len && h0 + j < 800; j++)
        step(h0 + j, v, $urandom_range(0, 7) == 0, 3'($urandom));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
